noc_rr_arbiter: RTL
===================

# noc_rr_arbiter

Parametrised round-robin output-port arbiter for the NoC router. It is the generalised successor of the fixed five-port (L/N/E/W/S) timed arbiter. It grants one of `NUM_PORTS` requesting input ports and holds the grant until one of three things happens: the request drops, a per-port packet-length timeout expires, or the owner presents a tail flit. Priority rotates from the last owner, including when coming out of idle. It sits between the input buffers and the crossbar select logic, one instance per output port.

## Interface
- `NUM_PORTS`, default 5: number of requesting input ports (≥2).
- `LEN_W`, default 12: width of packet length / timeout counter.
- `ID_W`, default 3: width of flit_id field per port.
- `HEADER_ID`, default 3'b001: flit_id value marking a header flit (loads timeout).
- `TAIL_ID`, default 3'b100: flit_id value marking a tail flit (early release).
- `clk` input, 1: single clock; all state updates on posedge.
- `rst` input, 1: synchronous, active-high reset.
- `req` input, NUM_PORTS: per-port request, bit i = port i.
- `flit_id` input, NUM_PORTS*ID_W: port i at bits [i*ID_W +: ID_W].
- `length` input, NUM_PORTS*LEN_W: port i at bits [i*LEN_W +: LEN_W].
- `grant` output, NUM_PORTS: registered one-hot grant; all-zero means idle.
- `grant_valid` output, 1: registered; equals |grant.
- `grant_idx` output, $clog2(NUM_PORTS): registered index of the owner; 0 when idle.
- `expired` output, 1: registered one-cycle pulse; the previous grant ended by timeout.

## Operation
- State: IDLE or OWN(i). Held in registered `grant`. Reset → IDLE: grant=0, grant_valid=0, grant_idx=0, expired=0, rr pointer=0, all counters and limits = 0.
- Per-port limit register `lim[i]`: loaded with `length[i]` on any cycle where `flit_id[i]==HEADER_ID`. Loading is independent of grant. Effective limit is `max(lim[i],1)`.
- Single shared hold counter `cnt` (LEN_W bits):
  - cleared on every grant change and in IDLE;
  - incremented each cycle OWN(i) is held;
  - saturates at all-ones.
- Timeout: in OWN(i), `tmo = (cnt == eff_lim[i]-1)`. The grant lasts at most eff_lim cycles.
- OWN(i) is retained next cycle iff all of: `req[i]`, `!tmo`, and `flit_id[i]!=TAIL_ID`.
- Release from OWN(i): search ports i+1, i+2, … (mod NUM_PORTS), excluding i. Grant the first one with req set. If none is found → IDLE.
  - The released owner is never re-granted back-to-back. It must pass through another owner or IDLE, matching the legacy behaviour.
- From IDLE: search starting at rr pointer (the last owner + 1, mod NUM_PORTS). Port i may be granted here.
- rr pointer is updated to (new owner + 1) mod NUM_PORTS on every transition into OWN.
- `expired` is set for one cycle following a release caused by `tmo`. It is also set if req and tail coincide with timeout. It is not set for release by req drop or tail alone.
- Any grant_idx or state outside the legal encoding → IDLE next cycle.

## Timing
- Grant latency: req rising at cycle t (sampled at edge t+1) → grant visible after edge t+1. That is one cycle from IDLE.
- Handover is zero-bubble: the cycle after the last OWN(i) cycle shows OWN(j). There is no IDLE cycle if another port is requesting.
- Tail release: the tail flit's cycle is the owner's last grant cycle.
- Limit update while the port is owner takes effect the next cycle. It does not reset `cnt`.
- Simultaneous header load and grant start on the same port: the grant uses the old `lim` on the first cycle and the new value thereafter.
- `rst` asserted mid-grant: state is IDLE after that edge, and all registers return to reset values. The first post-reset grant goes to the lowest requesting index.

## Test plan
- Reset then idle: rst for 2 cycles, req=0 → grant=0, grant_idx=0, expired=0 for 10 cycles. Then req=5'b00100 → grant=5'b00100 one cycle later.
- Timeout rotation, N=5: header loads length=3 on ports 0 and 2; req=5'b00101 held → grant 0 for 3 cycles, then port 2 for 3 cycles, then port 0, etc. `expired` pulses after each 3-cycle grant.
- Tail early release: port 1 owns, lim=10; flit_id[1]=TAIL_ID on the 2nd grant cycle, req[3]=1 → grant moves to port 3 after 2 cycles; expired=0.
- No back-to-back re-grant: only req[4]=1, lim=2 → grant 4 for 2 cycles, IDLE 1 cycle, grant 4 again. This repeats with period 3.
- Round-robin from idle: owner port 3 drops req; all idle one cycle; then req=5'b11111 → grant goes to port 4, not port 0.
- Reset mid-grant and parameter sweep: rst during OWN(2) → grant=0 next cycle. Repeat the scenarios with NUM_PORTS=8 and LEN_W=4, including length=0 (1-cycle grants) and cnt saturation with length=4'hF.

Source files
------------

// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin output-port arbiter; a grant is held until the request
// drops, the per-port length timeout expires, or the owner presents a tail flit.
module noc_rr_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int LEN_W = 12,
    parameter int ID_W = 3,
    parameter logic [ID_W-1:0] HEADER_ID = ID_W'(1),
    parameter logic [ID_W-1:0] TAIL_ID = ID_W'(4)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           req,
    input  logic [NUM_PORTS*ID_W-1:0]      flit_id,
    input  logic [NUM_PORTS*LEN_W-1:0]     length,
    output logic [NUM_PORTS-1:0]           grant,
    output logic                           grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0]   grant_idx,
    output logic                           expired
);
    localparam int IW = $clog2(NUM_PORTS);
    logic [NUM_PORTS-1:0][LEN_W-1:0] lim_q, lim_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d, rr_q, rr_d, pick;
    logic [LEN_W-1:0] cnt_q, cnt_d, own_lim, eff_lim;
    logic exp_q, exp_d, own, legal, own_req, own_tail, tmo, keep, found, go;
    int st;
    always_comb begin
        own_lim = '0;
        own_req = 1'b0;
        own_tail = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            lim_d[p] = (flit_id[p*ID_W +: ID_W] == HEADER_ID) ? length[p*LEN_W +: LEN_W] : lim_q[p];
            if (grant_q[p]) begin
                own_lim = lim_q[p];
                own_req = req[p];
                own_tail = flit_id[p*ID_W +: ID_W] == TAIL_ID;
            end
        end
        own = |grant_q;
        // Any grant/index pair that is not a matching one-hot (or clean idle) falls back to idle.
        legal = own ? (grant_q == (NUM_PORTS'(1) << idx_q)) : (idx_q == '0);
        eff_lim = (own_lim == '0) ? LEN_W'(1) : own_lim;
        tmo = own && legal && (cnt_q == eff_lim - 1'b1);
        keep = own && legal && own_req && !tmo && !own_tail;
        // A releasing owner searches from the next port and excludes itself; idle searches all.
        st = own ? (int'(idx_q) + 1) % NUM_PORTS : int'(rr_q);
        found = 1'b0;
        pick = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req[(st + k) % NUM_PORTS] && (k < NUM_PORTS - 1 || !own)) begin
                found = 1'b1;
                pick = IW'((st + k) % NUM_PORTS);
            end
        end
        go = legal && !keep && found;
        grant_d = keep ? grant_q : go ? (NUM_PORTS'(1) << pick) : '0;
        idx_d = keep ? idx_q : go ? pick : '0;
        cnt_d = keep ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
        exp_d = tmo;
        rr_d = go ? IW'((int'(pick) + 1) % NUM_PORTS) : rr_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            lim_q <= '0;
            grant_q <= '0;
            idx_q <= '0;
            rr_q <= '0;
            cnt_q <= '0;
            exp_q <= 1'b0;
        end else begin
            lim_q <= lim_d;
            grant_q <= grant_d;
            idx_q <= idx_d;
            rr_q <= rr_d;
            cnt_q <= cnt_d;
            exp_q <= exp_d;
        end
    end
    assign grant = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx = idx_q;
    assign expired = exp_q;
endmodule
